// File: rtl/dac_start_sequencer_if.sv
// Register-side and LUT-side signals of the DAC start sequencer.
// The master drives startDAC/sync and the sequencer (slave) returns playback control.
interface dac_start_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic [31:0]       start_reg;
  logic              sync_in;
  logic              dac_en;
  logic [ADDR_W-1:0] lut_addr;
  logic              lut_addr_rst;
  logic [31:0]       status;

  modport master (
    output start_reg, sync_in,
    input  dac_en, lut_addr, lut_addr_rst, status
  );

  modport slave (
    input  start_reg, sync_in,
    output dac_en, lut_addr, lut_addr_rst, status
  );
endinterface

// File: rtl/dac_start_sequencer.sv
// Arms on a startDAC run edge, optionally waits for sync, delays D+1 cycles,
// then plays the LUT address range with wrap counting until run drops.
module dac_start_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int LUT_LEN = 1024
) (
  input logic                  user_clk,
  input logic                  user_rst_n,
  dac_start_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LUT_LEN - 1);

  state_e            state_q;
  logic              run_q;
  logic              sync_q;
  logic              primed_q;
  logic [15:0]       cnt_q;
  logic [15:0]       wrap_cnt_q;
  logic [ADDR_W-1:0] lut_addr_q;
  logic              dac_en_q;
  logic              lut_addr_rst_q;
  logic [31:0]       status_q;

  logic        run_bit;
  logic        use_sync;
  logic [15:0] delay_val;
  logic        run_rise;
  logic        run_fall;
  logic        sync_rise;
  logic        unused_start_bits;

  assign run_bit           = bus.start_reg[0];
  assign use_sync          = bus.start_reg[1];
  assign delay_val         = bus.start_reg[31:16];
  assign unused_start_bits = ^bus.start_reg[15:2];

  // primed_q blocks a run bit that is already high out of reset from looking like a fresh edge
  assign run_rise  = run_bit & ~run_q & primed_q;
  assign run_fall  = ~run_bit & run_q;
  assign sync_rise = bus.sync_in & ~sync_q;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q        <= IDLE;
      run_q          <= 1'b0;
      sync_q         <= 1'b0;
      primed_q       <= 1'b0;
      cnt_q          <= '0;
      wrap_cnt_q     <= '0;
      lut_addr_q     <= '0;
      dac_en_q       <= 1'b0;
      lut_addr_rst_q <= 1'b0;
      status_q       <= '0;
    end else begin
      run_q          <= run_bit;
      sync_q         <= bus.sync_in;
      status_q       <= {state_q, 14'd0, wrap_cnt_q};
      lut_addr_rst_q <= 1'b0;
      if (!run_bit) begin
        primed_q <= 1'b1;
      end

      if (run_fall && (state_q != IDLE)) begin
        state_q    <= IDLE;
        dac_en_q   <= 1'b0;
        lut_addr_q <= '0;
        cnt_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (run_rise) begin
              state_q    <= ARMED;
              wrap_cnt_q <= '0;
            end
          end
          ARMED: begin
            if (!use_sync || sync_rise) begin
              state_q <= DELAY;
              cnt_q   <= delay_val;
            end
          end
          DELAY: begin
            if (cnt_q == 16'd0) begin
              state_q        <= RUN;
              lut_addr_q     <= '0;
              lut_addr_rst_q <= 1'b1;
              dac_en_q       <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          RUN: begin
            if (lut_addr_q == LAST_ADDR) begin
              lut_addr_q <= '0;
              if (wrap_cnt_q != 16'hFFFF) begin
                wrap_cnt_q <= wrap_cnt_q + 16'd1;
              end
            end else begin
              lut_addr_q <= lut_addr_q + ADDR_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.dac_en       = dac_en_q;
  assign bus.lut_addr     = lut_addr_q;
  assign bus.lut_addr_rst = lut_addr_rst_q;
  assign bus.status       = status_q;

endmodule

// File: doc/dac_start_sequencer.md
DAC_START_SEQUENCER -- requirements
Module: dac_start_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, width of the DAC LUT playback address.
REQ-002 SHALL have parameter LUT_LEN, default 1024, number of LUT entries played per pass; legal range 2..2^ADDR_W.
REQ-003 SHALL have port user_clk, input, 1, the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port user_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start_reg, input, 32, the startDAC software-register word, synchronous to user_clk. Fields: bit0 = run, bit1 = use_sync, bits[31:16] = delay D, other bits ignored.
REQ-006 SHALL have port sync_in, input, 1, external sync marker, synchronous to user_clk.
REQ-007 SHALL have port dac_en, output, 1, DAC output enable.
REQ-008 SHALL have port lut_addr, output, ADDR_W, LUT read address.
REQ-009 SHALL have port lut_addr_rst, output, 1, one-cycle pulse marking the first playback address.
REQ-010 SHALL have port status, output, 32: status[31:30] = state, status[29:16] = 0, status[15:0] = wrap_cnt.

Function
REQ-011 SHALL register start_reg[0] into run_q and sync_in into sync_q each cycle.
- run_rise = start_reg[0] & ~run_q
- run_fall = ~start_reg[0] & run_q
- sync_rise = sync_in & ~sync_q
REQ-012 SHALL implement four states, encoded as IDLE=0, ARMED=1, DELAY=2, RUN=3.
REQ-013 IDLE: on run_rise, SHALL go to ARMED next cycle; otherwise hold.
REQ-014 ARMED: if use_sync=0, SHALL go to DELAY next cycle; if use_sync=1, SHALL go to DELAY on the cycle after sync_rise.
REQ-015 SHALL ignore a sync_rise that coincides with run_rise in IDLE, since only ARMED reacts to sync.
REQ-016 On entering DELAY, SHALL load a 16-bit counter cnt with D.
REQ-017 In DELAY: if cnt=0, SHALL go to RUN next cycle; otherwise decrement cnt. DELAY therefore lasts exactly D+1 cycles; D=0 gives 1 cycle.
REQ-018 On entering RUN, SHALL set lut_addr=0 and pulse lut_addr_rst high for exactly that first RUN cycle.
REQ-019 In RUN, dac_en SHALL be 1; dac_en SHALL be 0 in all other states.
REQ-020 In RUN, lut_addr SHALL increment by 1 each cycle after the first RUN cycle.
REQ-021 At lut_addr=LUT_LEN-1, lut_addr SHALL wrap to 0 on the next cycle.
- lut_addr_rst does not pulse on wrap.
- wrap_cnt increments by 1 at each wrap, saturating at 16'hFFFF.
REQ-022 run_fall in any non-IDLE state SHALL force IDLE next cycle.
- dac_en = 0, lut_addr = 0, cnt = 0 on that transition.
- wrap_cnt holds its value.
- run_fall has priority over every other transition.
REQ-023 wrap_cnt SHALL clear to 0 on the IDLE->ARMED transition.
REQ-024 Changes to D or use_sync after leaving IDLE SHALL affect the sequence only at the points where they are sampled: D at DELAY entry, use_sync in ARMED.
REQ-025 All outputs SHALL be registered; status SHALL reflect state and wrap_cnt with 1-cycle latency.
REQ-026 A start_reg[0] held high SHALL NOT retrigger after a run_fall abort or after reset; a fresh 0->1 edge is required.

Reset
REQ-027 While user_rst_n=0, the block SHALL asynchronously force:
- state = IDLE
- run_q, sync_q, cnt, wrap_cnt = 0
- lut_addr = 0
- dac_en, lut_addr_rst = 0
- status = 0
REQ-028 SHALL release from reset synchronously on the first user_clk edge with user_rst_n=1.
REQ-029 Reset asserted mid-RUN SHALL drop dac_en within the same cycle, without waiting for a clock edge.

Verification
REQ-030 start_reg 0 -> 0x0003_0001 (D=3, use_sync=0):
- ARMED 1 cycle, DELAY 4 cycles.
- RUN entered with lut_addr=0, lut_addr_rst=1, dac_en=1.
REQ-031 LUT_LEN=8, run held high for 20 RUN cycles:
- lut_addr sequence 0..7,0..7,0..3.
- wrap_cnt=2, status[31:30]=3.
REQ-032 use_sync=1, D=0, sync_rise 10 cycles after ARMED entry:
- DELAY entered the cycle after sync_rise; RUN 1 cycle later.
- A sync_rise coincident with run_rise is ignored.
REQ-033 start_reg[0] cleared during DELAY and during RUN:
- IDLE next cycle, dac_en=0, lut_addr=0, wrap_cnt preserved.
- Keeping bit0 at 1 afterwards does not restart.
REQ-034 user_rst_n pulsed low mid-RUN:
- dac_en and lut_addr go to 0 immediately; status=0.
- After release with bit0 still 1, the block stays in IDLE until a new 0->1 edge.
